// File: rtl/ip_v4_header_check_if.sv
// Bus interface for the IPv4 header checker: word stream in, check result out.
// Optional field outputs are present when IP_V4_HDR_FIELDS_EN is defined.
interface ip_v4_header_check_if;
    logic        start;
    logic [31:0] d_in;
    logic        d_in_vld;
    logic        chk_vld;
    logic        hdr_ok;
    logic [1:0]  err_code;
    logic [15:0] chk_sum;
    logic        busy;
`ifdef IP_V4_HDR_FIELDS_EN
    logic [15:0] total_len;
    logic [7:0]  protocol;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;

    modport master (output start, d_in, d_in_vld,
                    input  chk_vld, hdr_ok, err_code, chk_sum, busy,
                           total_len, protocol, src_addr, dst_addr);
    modport slave  (input  start, d_in, d_in_vld,
                    output chk_vld, hdr_ok, err_code, chk_sum, busy,
                           total_len, protocol, src_addr, dst_addr);
`else
    modport master (output start, d_in, d_in_vld,
                    input  chk_vld, hdr_ok, err_code, chk_sum, busy);
    modport slave  (input  start, d_in, d_in_vld,
                    output chk_vld, hdr_ok, err_code, chk_sum, busy);
`endif
endinterface

// File: rtl/ip_v4_header_check.sv
// IPv4 RX header checker: accumulates the one's-complement sum over IHL words
// (checksum field included), checks version and IHL, reports pass/fail.
// Pipeline: last word at edge N -> FOLD -> fold register at N+1 -> outputs at N+2.
// Optional macro IP_V4_HDR_FIELDS_EN adds total_len/protocol/src_addr/dst_addr.
module ip_v4_header_check #(
    parameter int MIN_IHL = 5
) (
    input logic clk,
    input logic reset,
    ip_v4_header_check_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] FOLD    = 2'd2;

    logic [1:0]  state;
    logic [20:0] acc, acc_nxt;
    logic [3:0]  cnt, ihl, ihl_eff;
    logic [1:0]  err_q, err_p;
    logic [16:0] s;
    logic [15:0] fsum, sum_q;
    logic        pend, accept, last;
    logic        chk_vld_q, hdr_ok_q;
    logic [1:0]  err_code_q;
    logic [15:0] chk_sum_q;

    // Word acceptance; a start in the same cycle discards the word.
    assign accept  = (state == COLLECT) && !bus.start && bus.d_in_vld;
    assign ihl_eff = (cnt == 4'd0) ? bus.d_in[27:24] : ihl;
    assign last    = (cnt + 4'd1) == ihl_eff;

    // Accumulate next sum and fold the 21-bit accumulator to 16 bits.
    always_comb begin
        acc_nxt = acc + 21'(bus.d_in[31:16]) + 21'(bus.d_in[15:0]);
        s       = 17'(acc[15:0]) + 17'(acc[20:16]);
        fsum    = s[15:0] + 16'(s[16]);
    end

    // Header collection FSM with accumulator, word counter and early errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ihl   <= '0;
            err_q <= '0;
        end else if (bus.start) begin
            // start from any state (re)opens collection; FOLD result is already piped
            state <= COLLECT;
            acc   <= '0;
            cnt   <= '0;
            err_q <= '0;
        end else begin
            case (state)
                COLLECT: if (accept) begin
                    acc <= acc_nxt;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd0) begin
                        ihl <= bus.d_in[27:24];
                        if (bus.d_in[31:28] != 4'd4) begin
                            err_q <= 2'b10;
                            state <= FOLD;
                        end else if (bus.d_in[27:24] < 4'(MIN_IHL)) begin
                            err_q <= 2'b11;
                            state <= FOLD;
                        end
                    end else if (last) begin
                        state <= FOLD;
                    end
                end
                FOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Fold stage: capture folded sum and error so a new header may start in FOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend  <= 1'b0;
            sum_q <= '0;
            err_p <= '0;
        end else begin
            pend <= (state == FOLD);
            if (state == FOLD) begin
                sum_q <= fsum;
                err_p <= err_q;
            end
        end
    end

    // Result registers: one-cycle chk_vld/hdr_ok, err_code and chk_sum hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_vld_q  <= 1'b0;
            hdr_ok_q   <= 1'b0;
            err_code_q <= '0;
            chk_sum_q  <= '0;
        end else begin
            chk_vld_q <= pend;
            hdr_ok_q  <= 1'b0;
            if (pend) begin
                chk_sum_q <= sum_q;
                if (err_p != 2'b00)
                    err_code_q <= err_p;
                else if (sum_q != 16'hFFFF)
                    err_code_q <= 2'b01;
                else begin
                    err_code_q <= 2'b00;
                    hdr_ok_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.chk_vld  = chk_vld_q;
    assign bus.hdr_ok   = hdr_ok_q;
    assign bus.err_code = err_code_q;
    assign bus.chk_sum  = chk_sum_q;
    assign bus.busy     = (state != IDLE);

`ifdef IP_V4_HDR_FIELDS_EN
    logic [15:0] total_len_q;
    logic [7:0]  protocol_q;
    logic [31:0] src_addr_q, dst_addr_q;

    // Capture selected header fields as their words arrive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_len_q <= '0;
            protocol_q  <= '0;
            src_addr_q  <= '0;
            dst_addr_q  <= '0;
        end else if (accept) begin
            case (cnt)
                4'd0:    total_len_q <= bus.d_in[15:0];
                4'd2:    protocol_q  <= bus.d_in[23:16];
                4'd3:    src_addr_q  <= bus.d_in;
                4'd4:    dst_addr_q  <= bus.d_in;
                default: ;
            endcase
        end
    end

    assign bus.total_len = total_len_q;
    assign bus.protocol  = protocol_q;
    assign bus.src_addr  = src_addr_q;
    assign bus.dst_addr  = dst_addr_q;
`endif
endmodule

// File: doc/ip_v4_header_check.md
Name: ip_v4_header_check

Overview:
- Receive-side counterpart of the header checksum generator.
- Accepts an IPv4 header as a stream of 32-bit words after a `start` pulse and takes IHL from the first word.
- Computes the one's-complement sum over all IHL words, including the checksum field, and reports pass/fail with an error code.
- Sits in the RX path ahead of header parsing; words after the header (payload) are ignored until the next `start`.

Parameters:
- MIN_IHL, 5, smallest legal IHL in 32-bit words; below this the header is rejected.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; header words begin on the following cycles
- d_in  input  32  header word, big-endian (bits 31:24 = first byte on wire)
- d_in_vld  input  1  d_in valid this cycle; gaps allowed
- chk_vld  output  1  one-cycle pulse: result outputs valid
- hdr_ok  output  1  header passed all checks (qualified by chk_vld)
- err_code  output  2  00 none, 01 checksum, 10 version != 4, 11 IHL < MIN_IHL
- chk_sum  output  16  folded 16-bit one's-complement sum; 16'hFFFF for a correct header
- busy  output  1  high while a header is being collected or folded

Behaviour:
- Reset: clk/reset naming as in the codebase; reset is asynchronous, active-high.
  - All outputs reset to 0; FSM to IDLE; accumulator and counter cleared.
- FSM states: IDLE, COLLECT, FOLD.
- IDLE: d_in_vld ignored. start -> COLLECT, clear accumulator, word count = 0.
- COLLECT: each cycle with d_in_vld=1 accepts one word.
  - Accumulator (21 bits) += d_in[31:16] + d_in[15:0].
  - Count increments.
- First word:
  - Latch IHL = d_in[27:24] and version = d_in[31:28].
  - If version != 4: err_code=10, go to FOLD immediately.
  - Else if IHL < MIN_IHL: err_code=11, go to FOLD immediately.
- Word number IHL accepted -> FOLD.
- FOLD, one cycle:
  - s = acc[15:0] + acc[20:16].
  - chk_sum = s[15:0] + s[16].
  - On the next edge: register outputs, pulse chk_vld, return to IDLE.
- Latency: the last word is sampled at edge N; chk_vld, hdr_ok, err_code and chk_sum are valid from edge N+2 for exactly one cycle.
  - For version/IHL errors, the first word counts as the last word.
- hdr_ok = 1 only when err_code = 00 and chk_sum == 16'hFFFF. If the sum is not 16'hFFFF: err_code = 01, hdr_ok = 0.
- Outside the chk_vld cycle:
  - hdr_ok and chk_vld are 0.
  - err_code and chk_sum hold their last value.
- busy = 1 in COLLECT and FOLD.
- Boundary conditions:
  - start while in COLLECT: abort the current header with no chk_vld, restart the accumulator, stay in COLLECT.
  - start while in FOLD: the pending result is still reported on schedule, and the new header enters COLLECT.
  - start and d_in_vld in the same cycle: the word in that cycle is discarded; data is only accepted from the cycle after start.
  - Words with d_in_vld after the header (in IDLE) are ignored, with no error.
  - IHL=15: 15 words, 30 half-words × 0xFFFF < 2^21, so the accumulator never overflows.
  - reset mid-header: immediate return to IDLE; no chk_vld.

Optional Feature:
- Macro `IP_V4_HDR_FIELDS_EN`.
- Defined: adds output ports, all registered and valid with chk_vld, all reset to 0, holding their value until the next header's first word:
  - total_len[15:0] from word 0 [15:0]
  - protocol[7:0] from word 2 [23:16]
  - src_addr[31:0] = word 3
  - dst_addr[31:0] = word 4
- Not defined: these ports and their registers are absent; behaviour is otherwise identical.

Test Plan:
- Valid header:
  - Stimulus: start, then 4500_0073, 0000_4000, 4011_b861, c0a8_0001, c0a8_00c7, followed by 0035_e97c, 005f_279f, 1e4b_8180 (payload).
  - Response: chk_vld 2 cycles after the c0a8_00c7 edge; hdr_ok=1, err_code=00, chk_sum=FFFF.
  - The 3 payload words cause no second chk_vld.
  - With `IP_V4_HDR_FIELDS_EN`: total_len=0073, protocol=11, src_addr=c0a80001, dst_addr=c0a800c7.
- Corrupted checksum: same header with word 2 = 4011_b862 -> hdr_ok=0, err_code=01, chk_sum=0001.
- Gapped input: valid header with d_in_vld low for 3 cycles between each pair of words -> identical result; chk_vld still 2 edges after the last word.
- Bad version / IHL:
  - First word 6500_0073 -> chk_vld 2 cycles later, err_code=10, hdr_ok=0; the remaining words are ignored.
  - First word 4400_0073 -> err_code=11.
- Abort and back-to-back:
  - start, 2 words of a header, then start plus the full valid header -> exactly one chk_vld, with hdr_ok=1.
  - Four valid headers sent back-to-back, with start in the FOLD cycle of the previous header -> 4 chk_vld pulses, all with hdr_ok=1.
- Reset mid-header: assert reset after word 3 -> outputs 0 immediately, no chk_vld; a following valid header passes.
